// File: rtl/maze_pkg.sv
// Shared constants for the maze path checker: geometry, direction and
// error encodings, FSM state encoding and the row-major cell address helper.
package maze_pkg;

   localparam int MAZE_WIDTH  = 17;
   localparam int COORD_WIDTH = 5;
   localparam int STEP_WIDTH  = 9;

   localparam int CELLS      = MAZE_WIDTH * MAZE_WIDTH;
   localparam int ADDR_WIDTH = $clog2(CELLS);

   localparam logic [STEP_WIDTH-1:0]  MAXSTEP    = STEP_WIDTH'(CELLS - 1);
   localparam logic [COORD_WIDTH-1:0] LAST_COORD = COORD_WIDTH'(MAZE_WIDTH - 1);

   // Direction beat encoding from the solver
   localparam logic [1:0] RIGHT = 2'd0;  // y+1
   localparam logic [1:0] DOWN  = 2'd1;  // x+1
   localparam logic [1:0] LEFT  = 2'd2;  // y-1
   localparam logic [1:0] UP    = 2'd3;  // x-1

   // Rejection reasons reported on err_code
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_OOB   = 2'd1;
   localparam logic [1:0] ERR_WALL  = 2'd2;
   localparam logic [1:0] ERR_TRUNC = 2'd3;

   // Checker FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_TRACK  = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   // Row-major linear address of cell (x = row, y = column)
   function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [COORD_WIDTH-1:0] x,
                                                      input logic [COORD_WIDTH-1:0] y);
      return ADDR_WIDTH'(x) * ADDR_WIDTH'(MAZE_WIDTH) + ADDR_WIDTH'(y);
   endfunction

endpackage

// File: rtl/maze_path_checker_bitmap.sv
// One-bit-per-cell maze storage: synchronous write port used during load,
// combinational read port used to look up the cell a move lands on.
module maze_bitmap
   import maze_pkg::*;
(
   input  logic                   clk,
   input  logic                   wr_en,
   input  logic [COORD_WIDTH-1:0] wr_x,
   input  logic [COORD_WIDTH-1:0] wr_y,
   input  logic                   wr_bit,
   input  logic [COORD_WIDTH-1:0] rd_x,
   input  logic [COORD_WIDTH-1:0] rd_y,
   output logic                   rd_bit
);

   logic [CELLS-1:0]      cells;
   logic [ADDR_WIDTH-1:0] rd_addr;

   assign rd_addr = cell_addr(rd_x, rd_y);
   // Addresses past the last cell only occur for out-of-bounds moves, which
   // are rejected before the read value matters; return 0 to stay in range.
   assign rd_bit  = (rd_addr < ADDR_WIDTH'(CELLS)) ? cells[rd_addr] : 1'b0;

   // Store one cell per load beat
   // NOTE: no reset on the storage -- every load rewrites all cells before
   // tracking reads any of them. Non-blocking (<=) is used for all clocked
   // state so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         cells[cell_addr(wr_x, wr_y)] <= wr_bit;
      end
   end

endmodule

// File: rtl/maze_path_checker.sv
// Path checker for the maze BFS solver: snoops the maze bitstream into a
// bitmap, then walks the solver's direction stream from (0,0) and reports
// done on a legal arrival at the far corner or error with a reason code.
module maze_path_checker
   import maze_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   maze_valid,
   input  logic                   maze_in,
   input  logic                   dir_valid,
   input  logic [1:0]             dir_in,
   output logic [COORD_WIDTH-1:0] pos_x,
   output logic [COORD_WIDTH-1:0] pos_y,
   output logic [STEP_WIDTH-1:0]  step_cnt,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             err_code
);

   localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);
   localparam logic [TMO_WIDTH-1:0]   TMO_LAST = TMO_WIDTH'(TIMEOUT - 1);
   localparam logic [COORD_WIDTH:0]   EXT_ONE  = (COORD_WIDTH+1)'(1);
   localparam logic [COORD_WIDTH:0]   EXT_LAST = {1'b0, LAST_COORD};

   logic [1:0]             state;
   logic [COORD_WIDTH-1:0] load_x, load_y;
   logic [COORD_WIDTH-1:0] load_x_nxt, load_y_nxt;
   logic                   load_last;
   logic [TMO_WIDTH-1:0]   tmo_cnt;

   // Candidate position carries one extra bit so a step below 0 shows up as
   // a large value instead of wrapping to a legal coordinate.
   logic [COORD_WIDTH:0]   nxt_x, nxt_y;
   logic                   nxt_oob;
   logic                   nxt_open;
   logic                   nxt_target;
   logic                   bm_wr_en;

   assign bm_wr_en   = maze_valid && ((state == ST_IDLE) || (state == ST_LOAD));
   assign load_last  = (load_x == LAST_COORD) && (load_y == LAST_COORD);
   assign nxt_oob    = (nxt_x > EXT_LAST) || (nxt_y > EXT_LAST);
   assign nxt_target = (nxt_x == EXT_LAST) && (nxt_y == EXT_LAST);

   maze_bitmap u_bitmap (
      .clk    (clk),
      .wr_en  (bm_wr_en),
      .wr_x   (load_x),
      .wr_y   (load_y),
      .wr_bit (maze_in),
      .rd_x   (nxt_x[COORD_WIDTH-1:0]),
      .rd_y   (nxt_y[COORD_WIDTH-1:0]),
      .rd_bit (nxt_open)
   );

   // Candidate position for the current direction beat and next load cell
   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      nxt_x      = {1'b0, pos_x};
      nxt_y      = {1'b0, pos_y};
      load_x_nxt = load_x;
      load_y_nxt = load_y + COORD_WIDTH'(1);
      case (dir_in)
         RIGHT:   nxt_y = {1'b0, pos_y} + EXT_ONE;
         DOWN:    nxt_x = {1'b0, pos_x} + EXT_ONE;
         LEFT:    nxt_y = {1'b0, pos_y} - EXT_ONE;
         UP:      nxt_x = {1'b0, pos_x} - EXT_ONE;
         default: ;
      endcase
      if (load_y == LAST_COORD) begin
         load_y_nxt = '0;
         load_x_nxt = load_x + COORD_WIDTH'(1);
      end
   end

   // FSM, load counters, position/step/timeout tracking and result pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         load_x   <= '0;
         load_y   <= '0;
         tmo_cnt  <= '0;
         pos_x    <= '0;
         pos_y    <= '0;
         step_cnt <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (maze_valid) begin
                  pos_x    <= '0;
                  pos_y    <= '0;
                  step_cnt <= '0;
                  err_code <= ERR_NONE;
                  load_x   <= load_x_nxt;
                  load_y   <= load_y_nxt;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (maze_valid) begin
                  if (load_last) begin
                     load_x  <= '0;
                     load_y  <= '0;
                     tmo_cnt <= '0;
                     pos_x   <= '0;
                     pos_y   <= '0;
                     state   <= ST_TRACK;
                  end else begin
                     load_x <= load_x_nxt;
                     load_y <= load_y_nxt;
                  end
               end
            end
            ST_TRACK: begin
               if (dir_valid) begin
                  tmo_cnt <= '0;
                  if (nxt_oob) begin
                     err_code <= ERR_OOB;
                     error    <= 1'b1;
                     state    <= ST_REPORT;
                  end else if (!nxt_open) begin
                     err_code <= ERR_WALL;
                     error    <= 1'b1;
                     state    <= ST_REPORT;
                  end else if (step_cnt == MAXSTEP) begin
                     err_code <= ERR_TRUNC;
                     error    <= 1'b1;
                     state    <= ST_REPORT;
                  end else begin
                     pos_x    <= nxt_x[COORD_WIDTH-1:0];
                     pos_y    <= nxt_y[COORD_WIDTH-1:0];
                     step_cnt <= step_cnt + STEP_WIDTH'(1);
                     if (nxt_target) begin
                        done  <= 1'b1;
                        state <= ST_REPORT;
                     end
                  end
               end else if (step_cnt != '0) begin
                  // Stall watchdog only arms after the first accepted step
                  if (tmo_cnt == TMO_LAST) begin
                     err_code <= ERR_TRUNC;
                     error    <= 1'b1;
                     state    <= ST_REPORT;
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
                  end
               end
            end
            ST_REPORT: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
